// File: rtl/cv32e40p_prefetch_queue.sv
// cv32e40p_prefetch_queue: multi-outstanding instruction prefetch queue
// between the IF stage and the OBI instruction bus. Stale responses left
// in flight by a branch or a reset are dropped internally.
// Optional feature macro: CV32E40P_PREFETCH_ERR_EN (bus-error flag per
// entry, and a sticky halt of issue after an errored word).
// Handshakes: OBI address phase completes on instr_req_o && instr_gnt_i;
// once raised, instr_req_o and instr_addr_o hold until granted. The IF
// side accepts a word on fetch_valid_o && fetch_ready_i.
module cv32e40p_prefetch_queue #(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  input  logic        fetch_ready_i,
  output logic        fetch_valid_o,
  output logic [31:0] fetch_rdata_o,
  output logic [31:0] fetch_addr_o,
  output logic        fetch_err_o,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  output logic [31:0] instr_addr_o,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  output logic        busy_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1) + 1;
  localparam logic [31:0] DEPTH32   = 32'(DEPTH);
  localparam logic [31:0] MAX_OUT32 = 32'(MAX_OUTSTANDING);

  logic [31:0]   next_addr_q, next_addr_d;
  logic [31:0]   out_addr_q, out_addr_d;
  logic [31:0]   pend_addr_q, pend_addr_d;
  logic [31:0]   hold_addr_q, hold_addr_d;
  logic [OW-1:0] outstanding_q, outstanding_d;
  logic [OW-1:0] discard_q, discard_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic          pend_branch_q, pend_branch_d;
  logic          req_hold_q, req_hold_d;
  logic          hold_stale_q, hold_stale_d;
  logic          halt_q, halt_d;
  logic [31:0]   mem_q [DEPTH];

  logic [31:0]   branch_tgt, reserved, head_data;
  logic [OW-1:0] disc_max, disc_base;
  logic          live, drop, issue, fresh, gnt_fire, stale_gnt;
  logic          accept, push, pop, out_dec;

`ifdef CV32E40P_PREFETCH_ERR_EN
  logic          err_q [DEPTH];
  logic          head_err;
`else
  logic          unused_err;
  assign unused_err = instr_err_i;
`endif

  // Issue, delivery and next-state computation.
  always_comb begin
    branch_tgt = {branch_addr_i[31:2], 2'b00};
    drop       = instr_rvalid_i && (discard_q != '0);
    live       = instr_rvalid_i && (discard_q == '0);

    // Slots already promised: queued words plus live in-flight requests.
    reserved = branch_i ? 32'd0
                        : 32'(count_q) + 32'(outstanding_q) - 32'(discard_q);
    issue = req_i && !(halt_q && !branch_i) &&
            (32'(outstanding_q) < MAX_OUT32) &&
            (discard_q <= outstanding_q) && (reserved < DEPTH32);

    instr_req_o  = req_hold_q || issue;
    fresh        = !req_hold_q && issue;
    instr_addr_o = req_hold_q    ? hold_addr_q :
                   branch_i      ? branch_tgt  :
                   pend_branch_q ? pend_addr_q : next_addr_q;
    gnt_fire     = instr_req_o && instr_gnt_i;
    // A held request overtaken by a branch returns a word nobody wants.
    stale_gnt    = gnt_fire && req_hold_q && (hold_stale_q || branch_i);

    fetch_valid_o = !branch_i && ((count_q != '0) || live);
    head_data     = (count_q != '0) ? mem_q[rptr_q] :
                    (live ? instr_rdata_i : 32'd0);
    fetch_rdata_o = head_data;
    fetch_addr_o  = out_addr_q;
    accept        = fetch_valid_o && fetch_ready_i;
    push          = live && !branch_i && !((count_q == '0) && accept);
    pop           = accept && (count_q != '0);

    out_dec       = instr_rvalid_i && (outstanding_q != '0);
    outstanding_d = outstanding_q + OW'(gnt_fire) - OW'(out_dec);

    // After a reset discard can exceed outstanding; keep the larger.
    disc_max  = (discard_q > outstanding_q) ? discard_q : outstanding_q;
    disc_base = branch_i ? (disc_max - OW'(instr_rvalid_i && (disc_max != '0)))
                         : (discard_q - OW'(drop));
    discard_d = disc_base + OW'(stale_gnt);

    next_addr_d = next_addr_q;
    if (gnt_fire && !stale_gnt) next_addr_d = instr_addr_o + 32'd4;

    pend_branch_d = pend_branch_q;
    pend_addr_d   = pend_addr_q;
    if (branch_i && !fresh) begin
      pend_branch_d = 1'b1;
      pend_addr_d   = branch_tgt;
    end else if (fresh) begin
      pend_branch_d = 1'b0;
    end

    req_hold_d   = instr_req_o && !instr_gnt_i;
    hold_addr_d  = fresh ? instr_addr_o : hold_addr_q;
    hold_stale_d = req_hold_d && req_hold_q && (hold_stale_q || branch_i);

    out_addr_d = out_addr_q;
    if (branch_i)    out_addr_d = branch_tgt;
    else if (accept) out_addr_d = out_addr_q + 32'd4;

    count_d = branch_i ? '0 : count_q + CW'(push) - CW'(pop);
    rptr_d  = branch_i ? '0 : rptr_q + PW'(pop);
    wptr_d  = branch_i ? '0 : wptr_q + PW'(push);

`ifdef CV32E40P_PREFETCH_ERR_EN
    head_err    = (count_q != '0) ? err_q[rptr_q] : (live && instr_err_i);
    fetch_err_o = fetch_valid_o && head_err;
    halt_d      = branch_i ? 1'b0
                           : (halt_q || (accept && head_err) || (push && instr_err_i));
`else
    fetch_err_o = 1'b0;
    halt_d      = 1'b0;
`endif

    busy_o = instr_req_o || (outstanding_q != '0);
  end

  // Control state; reset keeps in-flight responses marked as stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      next_addr_q   <= '0;
      out_addr_q    <= '0;
      pend_addr_q   <= '0;
      hold_addr_q   <= '0;
      outstanding_q <= '0;
      discard_q     <= outstanding_d;
      count_q       <= '0;
      rptr_q        <= '0;
      wptr_q        <= '0;
      pend_branch_q <= 1'b0;
      req_hold_q    <= 1'b0;
      hold_stale_q  <= 1'b0;
      halt_q        <= 1'b0;
    end else begin
      next_addr_q   <= next_addr_d;
      out_addr_q    <= out_addr_d;
      pend_addr_q   <= pend_addr_d;
      hold_addr_q   <= hold_addr_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      rptr_q        <= rptr_d;
      wptr_q        <= wptr_d;
      pend_branch_q <= pend_branch_d;
      req_hold_q    <= req_hold_d;
      hold_stale_q  <= hold_stale_d;
      halt_q        <= halt_d;
    end
  end

  // FIFO storage; contents are only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= instr_rdata_i;
`ifdef CV32E40P_PREFETCH_ERR_EN
      err_q[wptr_q] <= instr_err_i;
`endif
    end
  end

endmodule
